// File: rtl/syscall_unit.sv
// syscall_unit: executes the syscall instruction for the pipelined CPU.
// It latches the service code ($v0) and argument ($a0) when a syscall is
// accepted, holds the pipeline while it works, streams ASCII bytes to the
// console over a valid/ready interface and halts the CPU on exit.
module syscall_unit #(
    parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
    parameter logic [31:0] CODE_EXIT       = 32'd10,
    parameter logic [31:0] CODE_PRINT_CHAR = 32'd11,
    parameter logic [31:0] CODE_PRINT_HEX  = 32'd34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_req,
    input  logic [31:0] pc,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        syscall_done,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        EMIT_DEC,
        EMIT_HEX,
        EMIT_CHAR,
        DONE,
        HALT
    } stateType;

    stateType    state;
    logic        isNeg;       // argument of PRINT_INT was negative
    logic [31:0] binShift;    // magnitude being shifted into the BCD register
    logic [39:0] bcdReg;      // ten BCD digits, most significant at the top
    logic [31:0] hexShift;    // remaining hex nibbles, next one at the top
    logic [4:0]  convCount;   // double-dabble shift index, 0..31
    logic [3:0]  bytesLeft;   // bytes still to present after the current one

    logic [31:0] magnitude;
    logic [39:0] adjBcd;
    logic [39:0] nextBcd;
    logic [3:0]  decDigits;
    logic [5:0]  alignShift;
    logic [39:0] alignedBcd;
    logic        knownCode;
    logic        txFire;
    logic        unusedPc;

    // pc only identifies the instruction in simulation traces; no logic here needs it.
    assign unusedPc = ^pc;

    // ASCII for one hex nibble, lowercase letters.
    function automatic logic [7:0] hexAscii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [39:0] dabbleAdjust(input logic [39:0] bcdIn);
        logic [39:0] r;
        r = bcdIn;
        for (int i = 0; i < 10; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Number of significant decimal digits; zero still counts as one digit.
    function automatic logic [3:0] digitCount(input logic [39:0] b);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 1; i < 10; i++) begin
            if (b[i*4 +: 4] != 4'd0) begin
                n = 4'(i + 1);
            end
        end
        return n;
    endfunction

    // Conversion datapath: next double-dabble step and MSD-aligned final digits.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        magnitude  = a0[31] ? (~a0 + 32'd1) : a0;
        adjBcd     = dabbleAdjust(bcdReg);
        nextBcd    = {adjBcd[38:0], binShift[31]};
        decDigits  = digitCount(nextBcd);
        alignShift = {4'd10 - decDigits, 2'b00};
        alignedBcd = nextBcd << alignShift;
    end

    assign knownCode = (v0 == CODE_PRINT_INT) || (v0 == CODE_EXIT) ||
                       (v0 == CODE_PRINT_CHAR) || (v0 == CODE_PRINT_HEX);
    assign txFire    = tx_valid & tx_ready;

    // NOTE: done must be combinational so an unknown code releases the pipeline in its accept cycle.
    assign syscall_done = (state == DONE) ||
                          ((state == IDLE) && syscall_req && !knownCode);
    assign stall        = syscall_req & ~syscall_done;

    // Main FSM: accept, convert, emit bytes with handshake, finish or halt.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            halted    <= 1'b0;
            isNeg     <= 1'b0;
            binShift  <= 32'd0;
            bcdReg    <= 40'd0;
            hexShift  <= 32'd0;
            convCount <= 5'd0;
            bytesLeft <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (syscall_req) begin
                        if (v0 == CODE_PRINT_CHAR) begin
                            tx_valid <= 1'b1;
                            tx_data  <= a0[7:0];
                            state    <= EMIT_CHAR;
                        end else if (v0 == CODE_PRINT_HEX) begin
                            tx_valid  <= 1'b1;
                            tx_data   <= hexAscii(a0[31:28]);
                            hexShift  <= {a0[27:0], 4'h0};
                            bytesLeft <= 4'd7;
                            state     <= EMIT_HEX;
                        end else if (v0 == CODE_PRINT_INT) begin
                            isNeg     <= a0[31];
                            binShift  <= magnitude;
                            bcdReg    <= 40'd0;
                            convCount <= 5'd0;
                            state     <= CONV;
                        end else if (v0 == CODE_EXIT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    end
                end

                CONV: begin
                    bcdReg    <= nextBcd;
                    binShift  <= {binShift[30:0], 1'b0};
                    convCount <= convCount + 5'd1;
                    if (convCount == 5'd31) begin
                        // Last shift: present the first byte straight from the final digits.
                        tx_valid <= 1'b1;
                        state    <= EMIT_DEC;
                        if (isNeg) begin
                            tx_data   <= 8'h2D;
                            bcdReg    <= alignedBcd;
                            bytesLeft <= decDigits;
                        end else begin
                            tx_data   <= {4'h3, alignedBcd[39:36]};
                            bcdReg    <= {alignedBcd[35:0], 4'h0};
                            bytesLeft <= decDigits - 4'd1;
                        end
                    end
                end

                EMIT_DEC: begin
                    if (txFire) begin
                        if (bytesLeft == 4'd0) begin
                            tx_valid <= 1'b0;
                            state    <= DONE;
                        end else begin
                            tx_data   <= {4'h3, bcdReg[39:36]};
                            bcdReg    <= {bcdReg[35:0], 4'h0};
                            bytesLeft <= bytesLeft - 4'd1;
                        end
                    end
                end

                EMIT_HEX: begin
                    if (txFire) begin
                        if (bytesLeft == 4'd0) begin
                            tx_valid <= 1'b0;
                            state    <= DONE;
                        end else begin
                            tx_data   <= hexAscii(hexShift[31:28]);
                            hexShift  <= {hexShift[27:0], 4'h0};
                            bytesLeft <= bytesLeft - 4'd1;
                        end
                    end
                end

                EMIT_CHAR: begin
                    if (txFire) begin
                        tx_valid <= 1'b0;
                        state    <= DONE;
                    end
                end

                DONE: state <= IDLE;

                HALT: state <= HALT;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: randomized syscalls compared against
// a string-level model of what the console should receive.
module tb_syscall_unit;

    logic        clk;
    logic        rst;
    logic        syscall_req;
    logic [31:0] pc;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        syscall_done;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        halted;

    int passCount  = 0;
    int checkCount = 0;

    // Results of the most recent drive_syscall run (cycle numbers relative to accept).
    string rxStr;
    int    doneAt;
    int    firstValidAt;
    int    haltedAt;
    int    stableErrs;
    int    stallErrs;

    syscall_unit dut (
        .clk          (clk),
        .rst          (rst),
        .syscall_req  (syscall_req),
        .pc           (pc),
        .v0           (v0),
        .a0           (a0),
        .stall        (stall),
        .syscall_done (syscall_done),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected console text for PRINT_INT: signed decimal by repeated division.
    function automatic string modelInt(input logic [31:0] arg);
        longint m;
        bit     neg;
        string  s;
        s   = "";
        m   = longint'($signed(arg));
        neg = (m < 0);
        if (neg) m = -m;
        do begin
            s = {$sformatf("%0d", m % 10), s};
            m = m / 10;
        end while (m != 0);
        if (neg) s = {"-", s};
        return s;
    endfunction

    // Expected console text for PRINT_HEX: eight lowercase nibbles, MSB first.
    function automatic string modelHex(input logic [31:0] arg);
        string s;
        int    nib;
        s = "";
        for (int i = 7; i >= 0; i--) begin
            nib = int'((arg >> (4 * i)) & 32'hF);
            s = {s, $sformatf("%c", (nib < 10) ? (48 + nib) : (87 + nib))};
        end
        return s;
    endfunction

    // Present one syscall with req held until done, collect transferred bytes.
    // readyMode: 0 = ready tied high, 1 = pattern 1,0,0,1, otherwise random.
    task automatic drive_syscall(input logic [31:0] code, input logic [31:0] arg,
                                 input int readyMode, input int budget, input bit keepReq);
        bit         prevHeld;
        logic [7:0] prevData;
        rxStr        = "";
        doneAt       = -1;
        firstValidAt = -1;
        haltedAt     = -1;
        stableErrs   = 0;
        stallErrs    = 0;
        prevHeld     = 1'b0;
        prevData     = 8'h00;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            syscall_req = 1'b1;
            v0          = code;
            a0          = arg;
            pc          = $urandom | 32'h4;
            case (readyMode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (tx_valid === 1'b1 && firstValidAt < 0) firstValidAt = k;
            if (halted === 1'b1 && haltedAt < 0) haltedAt = k;
            if (prevHeld && (tx_valid !== 1'b1 || tx_data !== prevData)) stableErrs++;
            prevHeld = (tx_valid === 1'b1) && !tx_ready;
            prevData = tx_data;
            if (tx_valid === 1'b1 && tx_ready) rxStr = {rxStr, $sformatf("%c", tx_data)};
            if (stall !== ~syscall_done) stallErrs++;
            if (syscall_done === 1'b1) begin
                doneAt = k;
                break;
            end
        end
        if (!keepReq) begin
            @(negedge clk);
            syscall_req = 1'b0;
            tx_ready    = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        syscall_req = 1'b0;
        tx_ready = 1'b1;
        v0 = 32'd0;
        a0 = 32'd0;
        pc = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkCount++;
        if (tx_valid !== 1'b0) $display("FAIL reset tx_valid: got %b expected 0", tx_valid); else passCount++;
        checkCount++;
        if (tx_data !== 8'h00) $display("FAIL reset tx_data: got %h expected 00", tx_data); else passCount++;
        checkCount++;
        if (halted !== 1'b0) $display("FAIL reset halted: got %b expected 0", halted); else passCount++;
        checkCount++;
        if (syscall_done !== 1'b0) $display("FAIL reset syscall_done: got %b expected 0", syscall_done); else passCount++;
        checkCount++;
        if (stall !== 1'b0) $display("FAIL reset stall: got %b expected 0", stall); else passCount++;
    endtask

    task automatic test_print_char();
        drive_syscall(32'd11, 32'h0000_0141, 0, 20, 1'b0);
        checkCount++;
        if (rxStr != "A") $display("FAIL char bytes: got \"%s\" expected \"A\"", rxStr); else passCount++;
        checkCount++;
        if (firstValidAt != 1) $display("FAIL char first valid: got %0d expected 1", firstValidAt); else passCount++;
        checkCount++;
        if (doneAt != 2) $display("FAIL char done cycle: got %0d expected 2", doneAt); else passCount++;
        checkCount++;
        if (stallErrs != 0) $display("FAIL char stall: got %0d bad cycles expected 0", stallErrs); else passCount++;
    endtask

    task automatic test_print_int_edges();
        logic [31:0] vals[5];
        string       exp;
        vals = '{32'h8000_0000, 32'd0, 32'd1234567, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        foreach (vals[i]) begin
            exp = modelInt(vals[i]);
            drive_syscall(32'd1, vals[i], 0, 80, 1'b0);
            checkCount++;
            if (rxStr != exp) $display("FAIL int bytes %h: got \"%s\" expected \"%s\"", vals[i], rxStr, exp); else passCount++;
            checkCount++;
            if (firstValidAt != 33) $display("FAIL int first valid %h: got %0d expected 33", vals[i], firstValidAt); else passCount++;
            checkCount++;
            if (doneAt != 33 + exp.len()) $display("FAIL int done cycle %h: got %0d expected %0d", vals[i], doneAt, 33 + exp.len()); else passCount++;
        end
    endtask

    task automatic test_print_int_random();
        logic [31:0] val;
        string       exp;
        for (int n = 0; n < 8; n++) begin
            val = (n % 2 == 0) ? $urandom : $urandom_range(0, 999);
            exp = modelInt(val);
            drive_syscall(32'd1, val, 2, 400, 1'b0);
            checkCount++;
            if (rxStr != exp) $display("FAIL int random bytes %h: got \"%s\" expected \"%s\"", val, rxStr, exp); else passCount++;
            checkCount++;
            if (stableErrs != 0) $display("FAIL int random hold %h: got %0d unstable cycles expected 0", val, stableErrs); else passCount++;
        end
    endtask

    task automatic test_print_hex();
        logic [31:0] val;
        string       exp;
        drive_syscall(32'd34, 32'hDEAD_BEEF, 1, 100, 1'b0);
        checkCount++;
        if (rxStr != "deadbeef") $display("FAIL hex bytes: got \"%s\" expected \"deadbeef\"", rxStr); else passCount++;
        checkCount++;
        if (stableErrs != 0) $display("FAIL hex hold: got %0d unstable cycles expected 0", stableErrs); else passCount++;
        checkCount++;
        if (firstValidAt != 1) $display("FAIL hex first valid: got %0d expected 1", firstValidAt); else passCount++;
        for (int n = 0; n < 4; n++) begin
            val = $urandom;
            exp = modelHex(val);
            drive_syscall(32'd34, val, 2, 300, 1'b0);
            checkCount++;
            if (rxStr != exp) $display("FAIL hex random bytes %h: got \"%s\" expected \"%s\"", val, rxStr, exp); else passCount++;
            checkCount++;
            if (stableErrs != 0) $display("FAIL hex random hold %h: got %0d unstable cycles expected 0", val, stableErrs); else passCount++;
        end
    endtask

    task automatic test_unknown_code();
        logic [31:0] codes[4];
        codes = '{32'd5, 32'd0, 32'd12, $urandom | 32'h100};
        foreach (codes[i]) begin
            drive_syscall(codes[i], $urandom, 0, 10, 1'b0);
            checkCount++;
            if (doneAt != 0) $display("FAIL unknown %0d done cycle: got %0d expected 0", codes[i], doneAt); else passCount++;
            checkCount++;
            if (stallErrs != 0 || firstValidAt != -1) $display("FAIL unknown %0d stall/tx: got %0d stall errors, first valid %0d expected 0 and -1", codes[i], stallErrs, firstValidAt); else passCount++;
        end
    endtask

    task automatic test_exit_and_reset();
        drive_syscall(32'd10, $urandom, 0, 101, 1'b0);
        #1;
        checkCount++;
        if (haltedAt != 1) $display("FAIL exit halted cycle: got %0d expected 1", haltedAt); else passCount++;
        checkCount++;
        if (doneAt != -1) $display("FAIL exit done: got cycle %0d expected none", doneAt); else passCount++;
        checkCount++;
        if (stallErrs != 0 || firstValidAt != -1) $display("FAIL exit stall/tx: got %0d stall errors, first valid %0d expected 0 and -1", stallErrs, firstValidAt); else passCount++;
        checkCount++;
        if (halted !== 1'b1) $display("FAIL exit sticky halted: got %b expected 1", halted); else passCount++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkCount++;
        if (halted !== 1'b0) $display("FAIL exit reset halted: got %b expected 0", halted); else passCount++;
        drive_syscall(32'd11, 32'h0000_005A, 0, 20, 1'b0);
        checkCount++;
        if (rxStr != "Z" || doneAt != 2) $display("FAIL exit recovery: got \"%s\" done %0d expected \"Z\" done 2", rxStr, doneAt); else passCount++;
    endtask

    task automatic test_reset_mid_conv();
        int validSeen;
        @(negedge clk);
        syscall_req = 1'b1;
        v0 = 32'd1;
        a0 = $urandom;
        pc = 32'h0040_0010;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        syscall_req = 1'b0;
        #1;
        checkCount++;
        if (tx_valid !== 1'b0 || syscall_done !== 1'b0 || stall !== 1'b0) $display("FAIL abort outputs: got valid %b done %b stall %b expected 0 0 0", tx_valid, syscall_done, stall); else passCount++;
        validSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (tx_valid === 1'b1) validSeen++;
        end
        checkCount++;
        if (validSeen != 0) $display("FAIL abort emission: got %0d valid cycles expected 0", validSeen); else passCount++;
        drive_syscall(32'd11, 32'h0000_0023, 0, 20, 1'b0);
        checkCount++;
        if (rxStr != "#" || doneAt != 2) $display("FAIL abort recovery: got \"%s\" done %0d expected \"#\" done 2", rxStr, doneAt); else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] val;
        string       exp;
        val = $urandom;
        exp = modelInt(val);
        drive_syscall(32'd11, 32'h0000_0042, 0, 20, 1'b1);
        checkCount++;
        if (rxStr != "B" || doneAt != 2) $display("FAIL b2b first: got \"%s\" done %0d expected \"B\" done 2", rxStr, doneAt); else passCount++;
        drive_syscall(32'd11, 32'h0000_0043, 0, 20, 1'b1);
        checkCount++;
        if (rxStr != "C" || doneAt != 2 || firstValidAt != 1) $display("FAIL b2b second: got \"%s\" done %0d valid %0d expected \"C\" done 2 valid 1", rxStr, doneAt, firstValidAt); else passCount++;
        drive_syscall(32'd1, val, 0, 80, 1'b0);
        checkCount++;
        if (rxStr != exp || doneAt != 33 + exp.len()) $display("FAIL b2b int: got \"%s\" done %0d expected \"%s\" done %0d", rxStr, doneAt, exp, 33 + exp.len()); else passCount++;
    endtask

    initial begin
        test_reset();
        test_print_char();
        test_print_int_edges();
        test_print_int_random();
        test_print_hex();
        test_unknown_code();
        test_exit_and_reset();
        test_reset_mid_conv();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
